// File: rtl/axis_flit_deserializer.sv
// rtl/axis_flit_deserializer.sv - credit-managed flit FIFO that reassembles router flits into AXI-Stream beats
module axis_flit_deserializer #(
   parameter int TDATA_WIDTH          = 512,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int DEST_WIDTH           = 6,
   parameter int TUSER_WIDTH          = 32,
   parameter int FLIT_BUFFER_DEPTH    = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
   input  logic [DEST_WIDTH-1:0]                     dest_in,
   input  logic [TUSER_WIDTH-1:0]                    user_in,
   input  logic                                      is_tail_in,
   input  logic                                      send_in,
   output logic                                      credit_out,
   output logic                                      axis_tvalid,
   input  logic                                      axis_tready,
   output logic [TDATA_WIDTH-1:0]                    axis_tdata,
   output logic                                      axis_tlast,
   output logic [TUSER_WIDTH-1:0]                    axis_tuser,
   output logic [DEST_WIDTH-1:0]                     axis_tdest,
   output logic                                      err_overflow
);

   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
   localparam int ENTRY_W    = FLIT_WIDTH + DEST_WIDTH + TUSER_WIDTH + 1;
   localparam int PTR_W      = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
   localparam int CNT_W      = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

   logic [ENTRY_W-1:0]     r_mem [FLIT_BUFFER_DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;

   logic [IDX_W-1:0]       r_idx;
   logic [TDATA_WIDTH-1:0] r_asm;
   logic [DEST_WIDTH-1:0]  r_dest;
   logic [TUSER_WIDTH-1:0] r_user;

   logic                   r_tvalid;
   logic [TDATA_WIDTH-1:0] r_tdata;
   logic                   r_tlast;
   logic [TUSER_WIDTH-1:0] r_tuser;
   logic [DEST_WIDTH-1:0]  r_tdest;
   logic                   r_credit;
   logic                   r_err;

   logic [ENTRY_W-1:0]     w_head;
   logic [FLIT_WIDTH-1:0]  w_head_data;
   logic [DEST_WIDTH-1:0]  w_head_dest;
   logic [TUSER_WIDTH-1:0] w_head_user;
   logic                   w_head_tail;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_final;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_overflow;
   logic [TDATA_WIDTH-1:0] w_beat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_data = w_head[ENTRY_W-1 -: FLIT_WIDTH];
   assign w_head_dest = w_head[TUSER_WIDTH+1 +: DEST_WIDTH];
   assign w_head_user = w_head[1 +: TUSER_WIDTH];
   assign w_head_tail = w_head[0];

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(FLIT_BUFFER_DEPTH));
   assign w_final    = (r_idx == IDX_W'(SERIALIZATION_FACTOR - 1)) || w_head_tail;
   // A final flit may only leave when the output register is free or drains this cycle.
   assign w_pop      = !w_empty && (!w_final || !r_tvalid || axis_tready);
   assign w_push     = send_in && (!w_full || w_pop);
   assign w_overflow = send_in && w_full && !w_pop;

   // Lanes at and above idx in r_asm are always zero, so only lane idx needs filling.
   always_comb begin
      w_beat = r_asm;
      w_beat[r_idx*FLIT_WIDTH +: FLIT_WIDTH] = w_head_data;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {data_in, dest_in, user_in, is_tail_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_asm    <= '0;
         r_dest   <= '0;
         r_user   <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         r_tuser  <= '0;
         r_tdest  <= '0;
         r_credit <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_credit <= w_pop;
         if (w_overflow) r_err <= 1'b1;

         if (r_tvalid && axis_tready) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
            r_tdest  <= '0;
         end

         // A reload in the same cycle as a handshake overrides the clear above.
         if (w_pop) begin
            if (w_final) begin
               r_tvalid <= 1'b1;
               r_tdata  <= w_beat;
               r_tlast  <= w_head_tail;
               r_tdest  <= (r_idx == '0) ? w_head_dest : r_dest;
               r_tuser  <= (r_idx == '0) ? w_head_user : r_user;
               r_idx    <= '0;
               r_asm    <= '0;
            end else begin
               r_asm[r_idx*FLIT_WIDTH +: FLIT_WIDTH] <= w_head_data;
               if (r_idx == '0) begin
                  r_dest <= w_head_dest;
                  r_user <= w_head_user;
               end
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign credit_out   = r_credit;
   assign axis_tvalid  = r_tvalid;
   assign axis_tdata   = r_tdata;
   assign axis_tlast   = r_tlast;
   assign axis_tuser   = r_tuser;
   assign axis_tdest   = r_tdest;
   assign err_overflow = r_err;

endmodule
